ok_upstream_packer: RTL and testbench
=====================================

Name: ok_upstream_packer

Overview:
Transmit-side framer for the upstream PC link. It accepts 32-bit upstream words from the core (8-bit code in bits 31:24, 24-bit payload in bits 23:0) over a valid/ack channel and buffers them in a FIFO. It serves them to the Opal-Kelly block pipe-out in fixed-length blocks, padding short blocks with upstream NOP words. It sits between the core's upstream channel and the OK pipe-out endpoint, and is the counterpart of the downstream word path.

Parameters:
NPCcode, 8, code field width
NPCdata, 24, payload field width (word width W = NPCcode+NPCdata = 32)
NOPcode, 64, code placed in padding words
BLOCK_WORDS, 128, words per pipe-out block (power of 2, >=2)
FIFO_DEPTH, 512, buffer depth (power of 2, >= 2*BLOCK_WORDS)
TIMEOUT_CYCLES, 10000, idle cycles before a partial block is flagged ready

Ports:
clk  in  1  design clock (okClk domain)
reset  in  1  asynchronous, active-high reset
in_d  in  W  upstream word from core
in_v  in  1  in_d valid
in_a  out  1  ack; transfer occurs on a clk edge where in_v && in_a
rd_en  in  1  pipe-out read strobe, one word per asserted cycle
rd_data  out  W  pipe-out word, registered
blk_ready  out  1  block available for the host to read
fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- One clock: clk. Reset is asynchronous and active-high. While reset is high: FIFO empty, fifo_count=0, in_a=0, rd_data=0, blk_ready=0, timer=0, state=IDLE.
- Input acceptance:
  - in_a = !full, combinational from the registered count; forced 0 during reset.
  - Words carrying NOPcode are buffered and sent unchanged; the block does not filter them.
- FIFO:
  - A simultaneous push and pop in one cycle leaves count unchanged.
  - Push when full cannot occur, because in_a=0.
  - Pop happens only as described under BURST.
- State machine, 2 states:
  - IDLE: on rd_en=1, latch commit = min(fifo_count, BLOCK_WORDS), clear the timer, and enter BURST. The same rd_en cycle counts as beat 0.
  - BURST: a beat counter counts rd_en cycles from 0 to BLOCK_WORDS-1.
    - On beat k with k < commit: pop the FIFO and load rd_data with the FIFO head.
    - Otherwise load rd_data = {NOPcode, NPCdata'b0}.
    - After the beat with index BLOCK_WORDS-1, return to IDLE.
    - rd_en=0 cycles stall the burst and rd_data holds its value.
  - rd_en in IDLE always starts a block, even with an empty FIFO; that block is all NOPs. The host never hangs.
  - Words pushed during a burst are not added to that burst; commit is fixed at burst start.
- Read latency: rd_data reflects the beat one cycle after the rd_en edge, i.e. registered 1-cycle latency.
- Timeout timer:
  - In IDLE, increments each cycle while 0 < fifo_count < BLOCK_WORDS.
  - Saturates at TIMEOUT_CYCLES.
  - Cleared when fifo_count==0 and at burst start.
  - Held during BURST.
- blk_ready:
  - Registered. In IDLE, 1 when fifo_count >= BLOCK_WORDS, or when fifo_count > 0 and timer == TIMEOUT_CYCLES.
  - 0 in BURST.
  - Updates one cycle after the condition becomes true.
- Reset asserted mid-burst: the burst is aborted and the FIFO contents discarded. After release, state is IDLE with all outputs at reset values.
- Width rules:
  - fifo_count is one bit wider than the address, so a full FIFO reads FIFO_DEPTH.
  - The beat counter is log2(BLOCK_WORDS) bits and wraps at block end.
  - Timer width is ceil(log2(TIMEOUT_CYCLES+1)).

Test Plan:
1. Push 128 words 0xFF000000+i with rd_en=0 -> blk_ready=1 one cycle after the 128th push. Then 128 rd_en cycles -> rd_data equals the pushed words in order, each one cycle after its strobe; fifo_count=0 at the end; blk_ready=0.
2. Push 5 words and wait TIMEOUT_CYCLES+2 cycles -> blk_ready=1. A 128-beat read -> 5 data words followed by 123 words of 0x40000000.
3. Empty FIFO, 128 rd_en cycles -> all rd_data=0x40000000; fifo_count stays 0.
4. Hold in_v=1 with no reads until 512 words are buffered -> fifo_count=512, in_a=0, no word lost. Then read 128 beats -> in_a=1 the cycle after the first pop; push/pop in the same cycle keeps count stable.
5. Start a burst with commit=3 and push 4 more words mid-burst -> the burst carries 3 data words + 125 NOPs; the next block starts with the 4 new words.
6. Assert reset at beat 50 of a burst -> rd_data=0, fifo_count=0, in_a=0 asynchronously. After release, in_a=1 and the next rd_en starts a fresh all-NOP block.

Source files
------------

// File: rtl/ok_upstream_packer_if.sv
// Upstream word channel (core -> packer) and Opal-Kelly pipe-out side (packer -> host).
// master = core/host side, slave = ok_upstream_packer.
interface ok_upstream_packer_if #(
   parameter int NPCcode    = 8,
   parameter int NPCdata    = 24,
   parameter int FIFO_DEPTH = 512
);
   localparam int W  = NPCcode + NPCdata;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [W-1:0]  in_d;
   logic          in_v;
   logic          in_a;
   logic          rd_en;
   logic [W-1:0]  rd_data;
   logic          blk_ready;
   logic [CW-1:0] fifo_count;

   modport master (
      output in_d, in_v, rd_en,
      input  in_a, rd_data, blk_ready, fifo_count
   );

   modport slave (
      input  in_d, in_v, rd_en,
      output in_a, rd_data, blk_ready, fifo_count
   );
endinterface

// File: rtl/ok_upstream_packer.sv
// Buffers upstream words in a FIFO and serves them as fixed-length pipe-out blocks,
// padding short blocks with NOP words and flagging partial blocks after an idle timeout.
module ok_upstream_packer #(
   parameter int NPCcode        = 8,
   parameter int NPCdata        = 24,
   parameter int NOPcode        = 64,
   parameter int BLOCK_WORDS    = 128,
   parameter int FIFO_DEPTH     = 512,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input logic clk,
   input logic reset,
   ok_upstream_packer_if.slave bus
);

   localparam int W  = NPCcode + NPCdata;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(BLOCK_WORDS);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CW-1:0] FULL_CNT    = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] BLK_CNT     = CW'(BLOCK_WORDS);
   localparam logic [BW:0]   COMMIT_FULL = (BW + 1)'(BLOCK_WORDS);
   localparam logic [BW-1:0] BEAT_LAST   = BW'(BLOCK_WORDS - 1);
   localparam logic [TW-1:0] TIMER_MAX   = TW'(TIMEOUT_CYCLES);
   localparam logic [W-1:0]  NOP_WORD    = {NPCcode'(NOPcode), {NPCdata{1'b0}}};

   typedef enum logic {IDLE, BURST} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [BW:0]   commit_q, commit_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [W-1:0]  rd_data_q, rd_data_d;
   logic          blk_ready_q, blk_ready_d;
   logic          in_a;
   logic          push;
   logic          pop;
   logic [W-1:0]  head;

   assign in_a = !reset && (count_q != FULL_CNT);
   assign push = bus.in_v && in_a;
   assign head = mem_q[rd_ptr_q];

   assign bus.in_a       = in_a;
   assign bus.rd_data    = rd_data_q;
   assign bus.blk_ready  = blk_ready_q;
   assign bus.fifo_count = count_q;

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      commit_d    = commit_q;
      timer_d     = timer_q;
      rd_data_d   = rd_data_q;
      blk_ready_d = 1'b0;
      pop         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.rd_en) begin
               // The starting strobe is beat 0; commit freezes how many real words this block carries.
               commit_d = (count_q < BLK_CNT) ? count_q[BW:0] : COMMIT_FULL;
               timer_d  = '0;
               beat_d   = BW'(1);
               state_d  = BURST;
               if (count_q != '0) begin
                  pop       = 1'b1;
                  rd_data_d = head;
               end else begin
                  rd_data_d = NOP_WORD;
               end
            end else begin
               if (count_q == '0) begin
                  timer_d = '0;
               end else if ((count_q < BLK_CNT) && (timer_q != TIMER_MAX)) begin
                  timer_d = timer_q + 1'b1;
               end
               blk_ready_d = (count_q >= BLK_CNT) ||
                             ((count_q != '0) && (timer_q == TIMER_MAX));
            end
         end
         BURST: begin
            if (bus.rd_en) begin
               if ({1'b0, beat_q} < commit_q) begin
                  pop       = 1'b1;
                  rd_data_d = head;
               end else begin
                  rd_data_d = NOP_WORD;
               end
               beat_d = beat_q + 1'b1;
               if (beat_q == BEAT_LAST) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         beat_q      <= '0;
         commit_q    <= '0;
         timer_q     <= '0;
         rd_data_q   <= '0;
         blk_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         beat_q      <= beat_d;
         commit_q    <= commit_d;
         timer_q     <= timer_d;
         rd_data_q   <= rd_data_d;
         blk_ready_q <= blk_ready_d;
      end
   end

   // Storage needs no reset; clearing the pointers discards the contents.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.in_d;
      end
   end

endmodule

// File: tb/tb_ok_upstream_packer.sv
// Testbench for ok_upstream_packer: directed scenarios plus random traffic,
// checked against a block-level reference model (word queue + burst bookkeeping).
module tb_ok_upstream_packer;

   localparam int BLK = 128;
   localparam int DEPTH = 512;
   localparam int TO = 10000;
   localparam logic [31:0] NOP = 32'h4000_0000;

   logic clk;
   logic reset;

   ok_upstream_packer_if #(.NPCcode(8), .NPCdata(24), .FIFO_DEPTH(DEPTH)) bus ();

   ok_upstream_packer #(
      .NPCcode(8), .NPCdata(24), .NOPcode(64), .BLOCK_WORDS(BLK),
      .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int compared = 0;
   int mismatched = 0;

   logic [31:0] mq[$];
   bit          m_burst;
   int          m_beat;
   int          m_commit;
   int          m_timer;
   logic        m_blk;
   logic [31:0] m_rd;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic model_reset();
      mq.delete();
      m_burst = 0;
      m_beat = 0;
      m_commit = 0;
      m_timer = 0;
      m_blk = 1'b0;
      m_rd = '0;
   endtask

   // One clock edge of the block-level behaviour, using the inputs held before the edge.
   task automatic model_step();
      int sz;
      bit acc;
      logic nb;
      if (reset) begin
         model_reset();
         return;
      end
      sz = mq.size();
      acc = bus.in_v && (sz < DEPTH);
      nb = !m_burst && !bus.rd_en && ((sz >= BLK) || (sz > 0 && m_timer == TO));
      if (!m_burst && !bus.rd_en) begin
         if (sz == 0) m_timer = 0;
         else if (sz < BLK && m_timer < TO) m_timer++;
      end
      if (bus.rd_en) begin
         if (!m_burst) begin
            m_commit = (sz < BLK) ? sz : BLK;
            m_beat = 0;
            m_burst = 1;
            m_timer = 0;
         end
         if (m_beat < m_commit) m_rd = mq.pop_front();
         else m_rd = NOP;
         m_beat++;
         if (m_beat == BLK) m_burst = 0;
      end
      if (acc) mq.push_back(bus.in_d);
      m_blk = nb;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.in_v = 1'b0;
      bus.in_d = '0;
      bus.rd_en = 1'b0;
      model_reset();
      repeat (3) tick();
      compared++;
      if (bus.rd_data !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_rd_data: got %h expected %h", bus.rd_data, 32'h0);
      end
      compared++;
      if (bus.fifo_count !== 10'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_count: got %0d expected 0", bus.fifo_count);
      end
      compared++;
      if (bus.in_a !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_in_a: got %b expected 0", bus.in_a);
      end
      compared++;
      if (bus.blk_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_blk_ready: got %b expected 0", bus.blk_ready);
      end
      #2 reset = 1'b0;
      #1;
      compared++;
      if (bus.in_a !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL release_in_a: got %b expected 1", bus.in_a);
      end
   endtask

   task automatic test_full_block();
      for (int i = 0; i < BLK; i++) begin
         bus.in_v = 1'b1;
         bus.in_d = 32'hFF00_0000 + 32'(i);
         tick();
         compared++;
         if (bus.fifo_count !== 10'(i + 1)) begin
            mismatched++;
            $display("[TB] FAIL full_push_count[%0d]: got %0d expected %0d", i, bus.fifo_count, i + 1);
         end
      end
      bus.in_v = 1'b0;
      tick();
      compared++;
      if (bus.blk_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL full_blk_ready: got %b expected 1", bus.blk_ready);
      end
      for (int i = 0; i < BLK; i++) begin
         bus.rd_en = 1'b1;
         tick();
         compared++;
         if (bus.rd_data !== 32'hFF00_0000 + 32'(i)) begin
            mismatched++;
            $display("[TB] FAIL full_rd_data[%0d]: got %h expected %h", i, bus.rd_data, 32'hFF00_0000 + 32'(i));
         end
         if (i == 10) begin
            compared++;
            if (bus.blk_ready !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL full_blk_in_burst: got %b expected 0", bus.blk_ready);
            end
         end
      end
      bus.rd_en = 1'b0;
      tick();
      compared++;
      if (bus.fifo_count !== 10'd0 || bus.blk_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL full_end_state: got count=%0d blk=%b expected count=0 blk=0", bus.fifo_count, bus.blk_ready);
      end
   endtask

   task automatic test_timeout_partial();
      logic [31:0] words[5];
      for (int i = 0; i < 5; i++) begin
         words[i] = $urandom;
         bus.in_v = 1'b1;
         bus.in_d = words[i];
         tick();
      end
      bus.in_v = 1'b0;
      repeat (TO - 20) tick();
      compared++;
      if (bus.blk_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL timeout_early_blk: got %b expected 0", bus.blk_ready);
      end
      repeat (22) tick();
      compared++;
      if (bus.blk_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL timeout_blk_ready: got %b expected 1", bus.blk_ready);
      end
      for (int i = 0; i < BLK; i++) begin
         bus.rd_en = 1'b1;
         tick();
         compared++;
         if (bus.rd_data !== ((i < 5) ? words[i] : NOP)) begin
            mismatched++;
            $display("[TB] FAIL timeout_rd_data[%0d]: got %h expected %h", i, bus.rd_data, (i < 5) ? words[i] : NOP);
         end
      end
      bus.rd_en = 1'b0;
      tick();
   endtask

   task automatic test_empty_read();
      for (int i = 0; i < BLK; i++) begin
         bus.rd_en = 1'b1;
         tick();
         compared++;
         if (bus.rd_data !== NOP || bus.fifo_count !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL empty_read[%0d]: got data=%h count=%0d expected data=%h count=0", i, bus.rd_data, bus.fifo_count, NOP);
         end
      end
      bus.rd_en = 1'b0;
      tick();
   endtask

   task automatic test_fill_full();
      int guard;
      bus.in_v = 1'b1;
      for (int i = 0; i < DEPTH + 8; i++) begin
         bus.in_d = $urandom;
         tick();
      end
      compared++;
      if (bus.fifo_count !== 10'(DEPTH) || bus.in_a !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL fill_full: got count=%0d in_a=%b expected count=%0d in_a=0", bus.fifo_count, bus.in_a, DEPTH);
      end
      for (int i = 0; i < BLK; i++) begin
         bus.in_d = $urandom;
         bus.rd_en = 1'b1;
         tick();
         compared++;
         if (bus.fifo_count !== 10'(DEPTH - 1) || bus.in_a !== 1'b1 || bus.rd_data !== m_rd) begin
            mismatched++;
            $display("[TB] FAIL fill_pushpop[%0d]: got count=%0d in_a=%b data=%h expected count=%0d in_a=1 data=%h",
                     i, bus.fifo_count, bus.in_a, bus.rd_data, DEPTH - 1, m_rd);
         end
      end
      bus.in_v = 1'b0;
      guard = 0;
      while ((mq.size() > 0 || m_burst) && guard < 2000) begin
         tick();
         guard++;
         compared++;
         if (bus.rd_data !== m_rd || bus.fifo_count !== 10'(mq.size())) begin
            mismatched++;
            $display("[TB] FAIL fill_drain[%0d]: got data=%h count=%0d expected data=%h count=%0d",
                     guard, bus.rd_data, bus.fifo_count, m_rd, mq.size());
         end
      end
      if (guard >= 2000) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL fill_drain_bound: got %0d cycles expected under 2000", guard);
      end
      bus.rd_en = 1'b0;
      tick();
   endtask

   task automatic test_commit_fixed();
      logic [31:0] first[3];
      logic [31:0] late[4];
      for (int i = 0; i < 3; i++) begin
         first[i] = $urandom;
         bus.in_v = 1'b1;
         bus.in_d = first[i];
         tick();
      end
      bus.in_v = 1'b0;
      tick();
      for (int b = 0; b < BLK; b++) begin
         bus.rd_en = 1'b1;
         bus.in_v = (b >= 1 && b <= 4);
         if (b >= 1 && b <= 4) begin
            late[b - 1] = $urandom;
            bus.in_d = late[b - 1];
         end
         tick();
         compared++;
         if (bus.rd_data !== ((b < 3) ? first[b] : NOP)) begin
            mismatched++;
            $display("[TB] FAIL commit_burst[%0d]: got %h expected %h", b, bus.rd_data, (b < 3) ? first[b] : NOP);
         end
      end
      bus.in_v = 1'b0;
      bus.rd_en = 1'b0;
      tick();
      compared++;
      if (bus.fifo_count !== 10'd4) begin
         mismatched++;
         $display("[TB] FAIL commit_left_count: got %0d expected 4", bus.fifo_count);
      end
      for (int b = 0; b < BLK; b++) begin
         bus.rd_en = 1'b1;
         tick();
         compared++;
         if (bus.rd_data !== ((b < 4) ? late[b] : NOP)) begin
            mismatched++;
            $display("[TB] FAIL commit_next[%0d]: got %h expected %h", b, bus.rd_data, (b < 4) ? late[b] : NOP);
         end
      end
      bus.rd_en = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_burst();
      bus.in_v = 1'b1;
      for (int i = 0; i < 60; i++) begin
         bus.in_d = $urandom;
         tick();
      end
      bus.in_v = 1'b0;
      bus.rd_en = 1'b1;
      repeat (50) tick();
      #2 reset = 1'b1;
      #1;
      model_reset();
      compared++;
      if (bus.rd_data !== 32'h0 || bus.fifo_count !== 10'd0 || bus.in_a !== 1'b0 || bus.blk_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL midburst_reset: got data=%h count=%0d in_a=%b blk=%b expected all 0",
                  bus.rd_data, bus.fifo_count, bus.in_a, bus.blk_ready);
      end
      bus.rd_en = 1'b0;
      repeat (2) tick();
      #2 reset = 1'b0;
      #1;
      compared++;
      if (bus.in_a !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL midburst_release_in_a: got %b expected 1", bus.in_a);
      end
      for (int i = 0; i < BLK; i++) begin
         bus.rd_en = 1'b1;
         tick();
         compared++;
         if (bus.rd_data !== NOP || bus.fifo_count !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL midburst_fresh[%0d]: got data=%h count=%0d expected data=%h count=0", i, bus.rd_data, bus.fifo_count, NOP);
         end
      end
      bus.rd_en = 1'b0;
      tick();
   endtask

   task automatic test_random_traffic();
      for (int c = 0; c < 1500; c++) begin
         bus.in_v = 1'($urandom_range(0, 1));
         bus.in_d = $urandom;
         bus.rd_en = ($urandom_range(0, 3) != 0);
         tick();
         compared++;
         if (bus.rd_data !== m_rd || bus.fifo_count !== 10'(mq.size()) ||
             bus.in_a !== (mq.size() < DEPTH) || bus.blk_ready !== m_blk) begin
            mismatched++;
            $display("[TB] FAIL random[%0d]: got data=%h count=%0d in_a=%b blk=%b expected data=%h count=%0d in_a=%b blk=%b",
                     c, bus.rd_data, bus.fifo_count, bus.in_a, bus.blk_ready,
                     m_rd, mq.size(), (mq.size() < DEPTH), m_blk);
         end
      end
      bus.in_v = 1'b0;
      bus.rd_en = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_full_block();
      test_timeout_partial();
      test_empty_read();
      test_fill_full();
      test_commit_fixed();
      test_reset_mid_burst();
      test_random_traffic();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
